bcd_scan_counter: RTL and testbench
===================================

# bcd_scan_counter

Parametrised multi-digit BCD counter with a time-multiplexed seven-segment driver. It replaces the single-digit counter/decoder. It adds:
- cascaded decades with up/down counting and count enable,
- a carry/borrow pulse on wrap,
- a digit-scan engine driving one shared segment bus and per-digit anode selects.

It sits between board-level control inputs (load switches, enable) and the display pins.

## Interface
- DIGITS, 4, number of BCD decades (1..8); digit 0 is least significant.
- SCAN_DIV, 1000, clk cycles each digit stays selected (>=2).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per clk while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load, priority over en.
- data  input  4*DIGITS  load value, digit k in bits [4k+3:4k].
- count  output  4*DIGITS  current counter value (registered).
- carry  output  1  one-cycle wrap pulse (registered).
- seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- an  output  DIGITS  digit selects, active-low, one-hot-low.

## Operation
- Reset (rst low, async):
  - count = 0, carry = 0.
  - Prescaler = 0, scan index = 0.
  - seg = 8'hFF, an = all ones.
- Counter priority each clk: load > en > hold.
- load: count <= data verbatim, carry <= 0. Digits >9 are stored unchanged.
- en, up=1:
  - Digit 0 increments.
  - A digit >=9 becomes 0 and carries into the next digit; otherwise it adds 1 and the ripple stops.
- en, up=0:
  - Digit 0 decrements.
  - A digit of 0 becomes 9 and borrows; a digit >9 becomes 9 with no borrow; otherwise it subtracts 1.
- carry <= 1 when the ripple passes the top digit:
  - up: all 9s -> all 0s.
  - down: all 0s -> all 9s.
  - carry <= 0 otherwise, including during load and hold.
- Scan engine:
  - The prescaler counts 0..SCAN_DIV-1 continuously, independent of en and load.
  - When the prescaler is at SCAN_DIV-1, the scan index advances 0 -> 1 -> ... -> DIGITS-1 -> 0.
- Display registers, every clk:
  - an <= ~(1 << index).
  - seg <= decode(count digit[index]).
- Decode, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99.
  - 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Values >9 = BF (dash, segment g only).
- dp (bit 7) is always 1 (off).

## Timing
- count and carry update on the clk edge where load or en is sampled. The new value is visible right after that edge.
- seg/an lag count and index by one clk (registered decode).
- Digit select period: SCAN_DIV clks per digit; full frame = DIGITS*SCAN_DIV clks.
- First cycle after reset release: an = ~1, and seg shows digit 0 of count.
- Simultaneous load and en: load wins; no step, no carry.
- rst asserted mid-operation: all state clears immediately, with no clock needed.
- Toggling up while en is held: the new direction applies from the next edge.

## Configuration
- BCD_LEADING_BLANK_EN defined:
  - A selected digit k>0 shows seg = FF when it and every higher digit are 0.
  - Digit 0 is never blanked.
  - an is still asserted for a blanked digit.
  - Blanking follows the same one-clk lag as seg.
- BCD_LEADING_BLANK_EN not defined: every digit always shows its decoded value.

## Test plan
Bench runs with DIGITS=4, SCAN_DIV=4.
- Reset/scan: release rst, en=0 -> count=0; an cycles E,D,B,7 every 4 clks; seg=C0 throughout (with BCD_LEADING_BLANK_EN: C0 for digit 0, FF for the others).
- Up wrap: load 16'h9998, then en=1 up=1 for 2 clks -> count 9999 then 0000; carry=1 only in the 0000 cycle.
- Down wrap: load 16'h0001, en=1 up=0 for 2 clks -> 0000 then 9999; carry high in the 9999 cycle; next step gives 9998 with carry=0.
- Load priority: count=0123, load=1 en=1 data=16'h4567 -> count=4567, no increment, carry=0.
- Invalid digit: load 16'h000C -> digit 0 displays BF. One up step -> 0010. Separately, load 000C and one down step -> 0009, no borrow.
- Async reset mid-count: assert rst between clk edges during counting -> count, carry and an clear before the next edge; seg=FF.

Source files
------------

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with carry pulse and a time-multiplexed,
// active-low seven-segment scan driver. Define BCD_LEADING_BLANK_EN to blank leading zeros.
module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'hC0;
      4'd1:    decode = 8'hF9;
      4'd2:    decode = 8'hA4;
      4'd3:    decode = 8'hB0;
      4'd4:    decode = 8'h99;
      4'd5:    decode = 8'h92;
      4'd6:    decode = 8'h82;
      4'd7:    decode = 8'hF8;
      4'd8:    decode = 8'h80;
      4'd9:    decode = 8'h90;
      default: decode = 8'hBF;
    endcase
  endfunction

  logic [4*DIGITS-1:0] count_nx;
  logic                carry_nx;
  logic                ripple;
  logic [3:0]          digit;

  logic [PW-1:0]       prescale;
  logic [IW-1:0]       index;
  logic [3:0]          sel_digit;
  logic [7:0]          seg_nx;
  logic [DIGITS-1:0]   an_nx;

  // Decade ripple: the carry/borrow walks upward from digit 0 and stops at
  // the first digit that absorbs it; a ripple surviving the top digit is a wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    count_nx = count;
    carry_nx = 1'b0;
    ripple   = 1'b1;
    digit    = '0;
    if (load) begin
      count_nx = data;
    end else if (en) begin
      for (int k = 0; k < DIGITS; k++) begin
        digit = count[4*k +: 4];
        if (ripple) begin
          if (up) begin
            if (digit >= 4'd9) begin
              count_nx[4*k +: 4] = 4'd0;
            end else begin
              count_nx[4*k +: 4] = digit + 4'd1;
              ripple             = 1'b0;
            end
          end else begin
            if (digit == 4'd0) begin
              count_nx[4*k +: 4] = 4'd9;
            end else if (digit > 4'd9) begin
              count_nx[4*k +: 4] = 4'd9;
              ripple             = 1'b0;
            end else begin
              count_nx[4*k +: 4] = digit - 4'd1;
              ripple             = 1'b0;
            end
          end
        end
      end
      carry_nx = ripple;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      count <= '0;
      carry <= 1'b0;
    end else begin
      count <= count_nx;
      carry <= carry_nx;
    end
  end

  // Free-running scan timing, unaffected by load/en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= '0;
      index    <= '0;
    end else if (prescale == PRE_LAST) begin
      prescale <= '0;
      index    <= (index == IDX_LAST) ? '0 : index + 1'b1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign sel_digit = count[4*index +: 4];
  assign an_nx     = ~(DIGITS'(1) << index);

`ifdef BCD_LEADING_BLANK_EN
  logic [DIGITS-1:0] zero_from;
  logic              zero_acc;

  // zero_from[k] is set when digit k and every higher digit are zero.
  always_comb begin
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_acc     = zero_acc & (count[4*k +: 4] == 4'd0);
      zero_from[k] = zero_acc;
    end
  end

  assign seg_nx = ((index != '0) && zero_from[index]) ? 8'hFF : decode(sel_digit);
`else
  assign seg_nx = decode(sel_digit);
`endif

  // Display outputs are registered, so they trail count/index by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= 8'hFF;
      an  <= '1;
    end else begin
      seg <= seg_nx;
      an  <= an_nx;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=4) with a queue scoreboard.
// Build with BCD_LEADING_BLANK_EN defined to exercise leading-zero blanking.
module tb_bcd_scan_counter;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [7:0] HI_ZERO = 8'hFF;
`else
  localparam logic [7:0] HI_ZERO = 8'hC0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] data;
  logic [15:0] count;
  logic        carry;
  logic [7:0]  seg;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  bcd_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .up    (up),
    .load  (load),
    .data  (data),
    .count (count),
    .carry (carry),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic l, input logic e, input logic u, input logic [15:0] d,
                     input logic [15:0] exp_count, input logic exp_carry, input string tag);
    load = l;
    en   = e;
    up   = u;
    data = d;
    push({tag, "_count"}, exp_count);
    push({tag, "_carry"}, {15'b0, exp_carry});
    step();
    check(count);
    check({15'b0, carry});
  endtask

  // Waits (bounded) until the given digit select is driven, then compares seg.
  task automatic show(input logic [3:0] target, input logic [7:0] exp_seg, input string tag);
    bit   ok;
    exp_t dummy;
    ok = 1'b0;
    push(tag, {8'h00, exp_seg});
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (an === target) ok = 1'b1;
    end
    if (ok) begin
      check({8'h00, seg});
    end else begin
      dummy = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s_timeout: an observed %h expected %h", dummy.tag, an, target);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_an;
    int         idx;

    rst  = 1'b0;
    en   = 1'b0;
    up   = 1'b1;
    load = 1'b0;
    data = '0;
    #12;
    push("rst_count", 16'h0000); check(count);
    push("rst_carry", 16'h0000); check({15'b0, carry});
    push("rst_seg",   16'h00FF); check({8'h00, seg});
    push("rst_an",    16'h000F); check({12'h000, an});

    // Release between edges and follow one full frame plus one digit.
    step();
    rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      idx    = ((k - 1) / SCAN_DIV) % DIGITS;
      exp_an = ~(4'b0001 << idx);
      push($sformatf("scan_an_%0d", k), {12'h000, exp_an});
      push($sformatf("scan_seg_%0d", k), {8'h00, (idx == 0) ? 8'hC0 : HI_ZERO});
      step();
      check({12'h000, an});
      check({8'h00, seg});
    end
    push("scan_count", 16'h0000); check(count);

    // Up wrap
    run(1, 0, 1, 16'h9998, 16'h9998, 0, "load_9998");
    run(0, 1, 1, 16'h0000, 16'h9999, 0, "up_9999");
    run(0, 1, 1, 16'h0000, 16'h0000, 1, "up_wrap");
    run(0, 0, 1, 16'h0000, 16'h0000, 0, "hold_after_wrap");

    // Down wrap
    run(1, 0, 0, 16'h0001, 16'h0001, 0, "load_0001");
    run(0, 1, 0, 16'h0000, 16'h0000, 0, "down_0000");
    run(0, 1, 0, 16'h0000, 16'h9999, 1, "down_wrap");
    run(0, 1, 0, 16'h0000, 16'h9998, 0, "down_9998");

    // Load beats enable, including where the step would have wrapped
    run(1, 0, 1, 16'h0123, 16'h0123, 0, "load_0123");
    run(1, 1, 1, 16'h4567, 16'h4567, 0, "load_over_en");
    run(1, 0, 1, 16'h9999, 16'h9999, 0, "load_9999");
    run(1, 1, 1, 16'h4567, 16'h4567, 0, "load_over_wrap");

    // Direction change while enabled applies on the next edge
    run(0, 1, 1, 16'h0000, 16'h4568, 0, "dir_up");
    run(0, 1, 0, 16'h0000, 16'h4567, 0, "dir_down");
    run(0, 0, 0, 16'h0000, 16'h4567, 0, "hold_4567");

    // Per-digit decode of 4567
    show(4'h7, 8'h99, "seg_d3_4");
    show(4'hB, 8'h92, "seg_d2_5");
    show(4'hD, 8'h82, "seg_d1_6");
    show(4'hE, 8'hF8, "seg_d0_7");

    // Out-of-range digit handling
    run(1, 0, 1, 16'h000C, 16'h000C, 0, "load_000C");
    load = 1'b0;
    show(4'hE, 8'hBF, "seg_invalid");
    show(4'hD, HI_ZERO, "seg_d1_zero");
    run(0, 1, 1, 16'h0000, 16'h0010, 0, "up_from_C");
    run(1, 0, 0, 16'h000C, 16'h000C, 0, "reload_000C");
    run(0, 1, 0, 16'h0000, 16'h0009, 0, "down_from_C");

    // Asynchronous reset between edges while counting
    run(1, 0, 1, 16'h1234, 16'h1234, 0, "load_1234");
    run(0, 1, 1, 16'h0000, 16'h1235, 0, "count_1235");
    #3;
    rst = 1'b0;
    #1;
    push("async_count", 16'h0000); check(count);
    push("async_carry", 16'h0000); check({15'b0, carry});
    push("async_an",    16'h000F); check({12'h000, an});
    push("async_seg",   16'h00FF); check({8'h00, seg});
    step();
    rst = 1'b1;
    run(0, 1, 1, 16'h0000, 16'h0001, 0, "after_reset");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
